// File: rtl/tcm_ctrl_pkg.sv
// ============================================================================
// Module : tcm_ctrl_pkg
// Brief  : Shared FSM encodings, word-offset constant and response-info type
//          for the TCM bus controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tcm_ctrl_pkg;

   localparam logic [0:0]  TCM_IDLE     = 1'b0;
   localparam logic [0:0]  TCM_RSP      = 1'b1;
   localparam int unsigned TCM_WORD_OFS = 2;

   typedef struct packed {
      logic wr;
      logic err;
   } tcm_rsp_info_t;

endpackage

`default_nettype wire

// File: rtl/tcm_ctrl_if.sv
// ============================================================================
// Module : tcm_ctrl_if
// Brief  : Command/response valid-ready bus between a requester (master) and
//          the TCM controller (slave).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface tcm_ctrl_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = 4
) ();

   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [MW-1:0] cmd_wmask;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

`default_nettype wire

// File: rtl/tcm_ctrl.sv
// ============================================================================
// Module : tcm_ctrl
// Brief  : Single-outstanding valid/ready controller in front of a 1-cycle
//          single-port TCM SRAM. Optional range check: TCM_CTRL_ADDR_CHK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tcm_ctrl
   import tcm_ctrl_pkg::*;
#(
   parameter int DP  = 512,
   parameter int DW  = 32,
   parameter int MW  = 4,
   parameter int AW  = 32,
   parameter int RAW = 9
) (
   input  wire logic           clk,
   input  wire logic           rst,
   tcm_ctrl_if.slave           bus,
   output logic [RAW-1:0]      ram_addr,
   output logic [DW-1:0]      ram_din,
   output logic                ram_we,
   output logic [MW-1:0]       ram_wem,
   input  wire logic [DW-1:0] ram_dout
);

   logic [0:0]     r_state;
   logic [0:0]     w_state_nxt;
   logic [RAW-1:0] r_addr_q;
   tcm_rsp_info_t  r_info;
   logic           w_acc;
   logic           w_oor;
   logic           w_rsp_valid;
   logic [RAW-1:0] w_cmd_word;
   logic           w_unused;

   assign w_cmd_word = bus.cmd_addr[RAW+TCM_WORD_OFS-1:TCM_WORD_OFS];
   assign w_unused   = ^{bus.cmd_addr[TCM_WORD_OFS-1:0], bus.cmd_addr[AW-1:RAW+TCM_WORD_OFS]};

`ifdef TCM_CTRL_ADDR_CHK_EN
   assign w_oor = ({2'b00, bus.cmd_addr[AW-1:TCM_WORD_OFS]} >= AW'(DP));
`else
   assign w_oor = 1'b0;
`endif

   assign w_rsp_valid   = (r_state == TCM_RSP);
   assign bus.cmd_ready = ~rst & (~w_rsp_valid | bus.rsp_ready);
   assign w_acc         = bus.cmd_valid & bus.cmd_ready;

   // Holding the last address keeps the RAM re-reading the same word, so
   // read data stays stable while the response is stalled.
   assign ram_addr = w_acc ? w_cmd_word : r_addr_q;
   assign ram_din  = bus.cmd_wdata;
   assign ram_wem  = bus.cmd_wmask;
   assign ram_we   = w_acc & bus.cmd_write & ~w_oor;

   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_err   = r_info.err;
   assign bus.rsp_rdata = (w_rsp_valid & ~r_info.wr & ~r_info.err) ? ram_dout : '0;

   always_comb begin
      w_state_nxt = r_state;
      if (w_acc) begin
         w_state_nxt = TCM_RSP;
      end else if (w_rsp_valid && bus.rsp_ready) begin
         w_state_nxt = TCM_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= TCM_IDLE;
         r_addr_q   <= '0;
         r_info.wr  <= 1'b0;
         r_info.err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_acc) begin
            r_addr_q   <= w_cmd_word;
            r_info.wr  <= bus.cmd_write;
            r_info.err <= w_oor;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tcm_ctrl.sv
// ============================================================================
// Module : tb_tcm_ctrl
// Brief  : Scoreboard bench for tcm_ctrl with a byte-level memory reference.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tcm_ctrl;

   localparam int DP  = 512;
   localparam int DW  = 32;
   localparam int MW  = 4;
   localparam int AW  = 32;
   localparam int RAW = 9;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [RAW-1:0] ram_addr;
   logic [DW-1:0]  ram_din;
   logic [DW-1:0]  ram_dout;
   logic           ram_we;
   logic [MW-1:0]  ram_wem;

   logic [DW-1:0]  mem [DP];
   logic [7:0]     ref_b [DP*4];
   exp_t           sb [$];
   int             checks = 0;
   int             failures = 0;
   bit             rr_rand = 1'b0;

   always #5 clk = ~clk;

   tcm_ctrl_if #(.AW(AW), .DW(DW), .MW(MW)) bus ();

   tcm_ctrl #(.DP(DP), .DW(DW), .MW(MW), .AW(AW), .RAW(RAW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_wem  (ram_wem),
      .ram_dout (ram_dout)
   );

   // Single-port RAM: writes on we, otherwise re-reads the presented address.
   always @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < MW; b++)
            if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
         ram_dout <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit out_of_range(input logic [31:0] addr);
`ifdef TCM_CTRL_ADDR_CHK_EN
      return (addr >> 2) >= DP;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      int unsigned base;
      logic [31:0] v;
      base = ((addr >> 2) % DP) * 4;
      for (int b = 0; b < 4; b++) v[8*b +: 8] = ref_b[base + b];
      return v;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] m);
      int unsigned base;
      base = ((addr >> 2) % DP) * 4;
      for (int b = 0; b < 4; b++)
         if (m[b]) ref_b[base + b] = d[8*b +: 8];
   endfunction

   // Called right after a falling edge; returns at the falling edge after acceptance.
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] wm, output int waits, output bit we_seen,
                        output logic [RAW-1:0] wa);
      exp_t e;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.cmd_wmask = wm;
      waits   = 0;
      we_seen = 1'b0;
      wa      = '0;
      #1;
      while (!bus.cmd_ready && waits < 50) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!bus.cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=stalled required=accept addr=%h", addr);
      end else begin
         we_seen = ram_we;
         wa      = ram_addr;
         if (out_of_range(addr)) begin
            e.d = 32'h0;
            e.e = 1'b1;
         end else if (wr) begin
            model_write(addr, wd, wm);
            e.d = 32'h0;
            e.e = 1'b0;
         end else begin
            e.d = model_read(addr);
            e.e = 1'b0;
         end
         sb.push_back(e);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rr_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: a response handshake completes at the coming rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
            end else begin
               e = sb.pop_front();
               chk("rsp_rdata", bus.rsp_rdata, e.d);
               chk("rsp_err", 32'(bus.rsp_err), 32'(e.e));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int             w;
      bit             we;
      logic [RAW-1:0] wa;
      logic [31:0]    a;

      for (int i = 0; i < DP; i++) mem[i] = '0;
      for (int i = 0; i < DP*4; i++) ref_b[i] = 8'h00;
      ram_dout      = '0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h10;
      bus.cmd_wdata = 32'h12345678;
      bus.cmd_wmask = 4'hF;
      bus.rsp_ready = 1'b1;

      @(negedge clk);
      #1;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("reset_ram_we", 32'(ram_we), 32'd0);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Write then read
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, w, we, wa);
      chk("wr_ram_we", 32'(we), 32'd1);
      chk("wr_ram_addr", 32'(wa), 32'd4);
      issue(1'b0, 32'h10, 32'h0, 4'h0, w, we, wa);
      chk("rd_ram_we", 32'(we), 32'd0);
      #1;
      chk("rd_latency_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rd_latency_data", bus.rsp_rdata, 32'hDEADBEEF);
      @(negedge clk);

      // Partial write
      issue(1'b1, 32'h10, 32'h11223344, 4'hF, w, we, wa);
      issue(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, w, we, wa);
      issue(1'b0, 32'h10, 32'h0, 4'h0, w, we, wa);
      #1;
      chk("partial_data", bus.rsp_rdata, 32'h11BB33DD);
      @(negedge clk);

      // Zero-mask write: response only, data untouched
      issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, w, we, wa);
      issue(1'b0, 32'h10, 32'h0, 4'h0, w, we, wa);

      // Backpressure
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, w, we, wa);
      issue(1'b0, 32'h10, 32'h0, 4'h0, w, we, wa);
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h20;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("stall_rdata", bus.rsp_rdata, 32'hDEADBEEF);
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);

      // Streaming
      for (int i = 0; i < 8; i++) begin
         issue(1'b1, 32'(i*4), 32'hA5000000 + 32'(i), 4'hF, w, we, wa);
      end
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 32'(i*4), 32'h0, 4'h0, w, we, wa);
         chk("stream_no_stall", 32'(w), 32'd0);
      end
      #3;
      chk("stream_drained", 32'(sb.size()), 32'd0);
      @(negedge clk);

      // Reset mid-operation
      bus.rsp_ready = 1'b0;
      issue(1'b0, 32'h10, 32'h0, 4'h0, w, we, wa);
      #1;
      chk("midrst_pending", 32'(bus.rsp_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      issue(1'b0, 32'h10, 32'h0, 4'h0, w, we, wa);

      // Address wrap / range
      issue(1'b1, 32'h800, 32'hCAFEF00D, 4'hF, w, we, wa);
`ifdef TCM_CTRL_ADDR_CHK_EN
      chk("range_no_we", 32'(we), 32'd0);
`else
      chk("alias_we", 32'(we), 32'd1);
      chk("alias_addr", 32'(wa), 32'd0);
`endif
      issue(1'b0, 32'h0, 32'h0, 4'h0, w, we, wa);
      issue(1'b0, 32'h800, 32'h0, 4'h0, w, we, wa);

      // Randomized traffic with random response backpressure
      rr_rand = 1'b1;
      for (int n = 0; n < 300; n++) begin
         a = 32'($urandom_range(0, DP*8 - 1));
         issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), w, we, wa);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      rr_rand = 1'b0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      #3;
      chk("final_drain", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
